// File: rtl/regbank16x4_wr.sv
// rtl/regbank16x4_wr.sv - 16 x 4-bit register bank with write-ack port and sequenced bank clear
//
// Optional build macro: REGBANK_WMASK_EN (adds per-bit write mask input wmask).
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   we        - write request
//   waddr     - write entry index 0..15
//   wdata     - write data
//   wmask     - per-bit write enable (only with REGBANK_WMASK_EN)
//   wr_ack    - one-cycle pulse after an accepted write
//   clr_req   - start bank clear (level, sampled only in IDLE)
//   clr_busy  - clear sequence in progress
//   clr_done  - one-cycle pulse after entry 15 is cleared
//   q0..qf    - entry contents, driven straight from flops

module regbank16x4_wr #(
    parameter logic [3:0] RESET_VAL = 4'h0,
    parameter logic [3:0] CLR_VAL   = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [3:0] wdata,
`ifdef REGBANK_WMASK_EN
    input  logic [3:0] wmask,
`endif
    output logic       wr_ack,
    input  logic       clr_req,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [3:0] q3,
    output logic [3:0] q4,
    output logic [3:0] q5,
    output logic [3:0] q6,
    output logic [3:0] q7,
    output logic [3:0] q8,
    output logic [3:0] q9,
    output logic [3:0] qa,
    output logic [3:0] qb,
    output logic [3:0] qc,
    output logic [3:0] qd,
    output logic [3:0] qe,
    output logic [3:0] qf
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] clr_idx;
    logic [3:0] mem [16];
    logic [3:0] wr_word;

    // Word to store on an accepted write; with the mask, unselected bits keep
    // the current entry value.
    always_comb begin
        wr_word = wdata;
`ifdef REGBANK_WMASK_EN
        wr_word = (mem[waddr] & ~wmask) | (wdata & wmask);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= RESET_VAL;
            end
            state    <= IDLE;
            clr_idx  <= 4'd0;
            wr_ack   <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            wr_ack   <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear has priority: a coincident write is dropped.
                    if (clr_req) begin
                        mem[0]   <= CLR_VAL;
                        clr_idx  <= 4'd1;
                        clr_busy <= 1'b1;
                        state    <= CLEAR;
                    end else if (we) begin
                        mem[waddr] <= wr_word;
                        wr_ack     <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Writes are ignored here; the requester retries after clr_busy falls.
                    mem[clr_idx] <= CLR_VAL;
                    if (clr_idx == 4'd15) begin
                        clr_idx  <= 4'd0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        clr_idx <= clr_idx + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign q0 = mem[0];
    assign q1 = mem[1];
    assign q2 = mem[2];
    assign q3 = mem[3];
    assign q4 = mem[4];
    assign q5 = mem[5];
    assign q6 = mem[6];
    assign q7 = mem[7];
    assign q8 = mem[8];
    assign q9 = mem[9];
    assign qa = mem[10];
    assign qb = mem[11];
    assign qc = mem[12];
    assign qd = mem[13];
    assign qe = mem[14];
    assign qf = mem[15];

endmodule

// File: tb/tb_regbank16x4_wr.sv
// tb/tb_regbank16x4_wr.sv - directed self-checking bench for regbank16x4_wr

module tb_regbank16x4_wr;

    logic       clk;
    logic       rst;
    logic       we;
    logic [3:0] waddr;
    logic [3:0] wdata;
`ifdef REGBANK_WMASK_EN
    logic [3:0] wmask;
`endif
    logic       wr_ack;
    logic       clr_req;
    logic       clr_busy;
    logic       clr_done;
    logic [3:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [3:0] q8, q9, qa, qb, qc, qd, qe, qf;
    logic [3:0] qv [16];

    int nvec;
    int nerr;
    int busy_cnt;

    regbank16x4_wr #(
        .RESET_VAL(4'h0),
        .CLR_VAL  (4'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
`ifdef REGBANK_WMASK_EN
        .wmask   (wmask),
`endif
        .wr_ack  (wr_ack),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .q8(q8), .q9(q9), .qa(qa), .qb(qb),
        .qc(qc), .qd(qd), .qe(qe), .qf(qf)
    );

    always_comb qv = '{q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, qa, qb, qc, qd, qe, qf};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        we = 1'b0;
        waddr = 4'h0;
        wdata = 4'h0;
        clr_req = 1'b0;
`ifdef REGBANK_WMASK_EN
        wmask = 4'hF;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        for (int i = 0; i < 16; i++) chk($sformatf("reset_q%0d", i), 8'(qv[i]), 8'h0);
        chk("reset_busy", 8'(clr_busy), 8'h0);
        chk("reset_ack", 8'(wr_ack), 8'h0);
        chk("reset_done", 8'(clr_done), 8'h0);

        // Asynchronous reset between edges
        we = 1'b1; waddr = 4'h5; wdata = 4'hA;
        tick();
        we = 1'b0;
        chk("pre_async_q5", 8'(q5), 8'hA);
        chk("pre_async_ack", 8'(wr_ack), 8'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_q5", 8'(q5), 8'h0);
        chk("async_rst_ack", 8'(wr_ack), 8'h0);
        rst = 1'b0;
        tick();

        // Write sweep
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 4'(i) ^ 4'hF;
            tick();
            chk($sformatf("sweep_ack%0d", i), 8'(wr_ack), 8'h1);
            chk($sformatf("sweep_q%0d", i), 8'(qv[i]), 8'(4'(i) ^ 4'hF));
        end
        we = 1'b0;
        tick();
        chk("sweep_ack_end", 8'(wr_ack), 8'h0);
        for (int i = 0; i < 16; i++) chk($sformatf("sweep_hold_q%0d", i), 8'(qv[i]), 8'(4'(i) ^ 4'hF));

        // Same-address back-to-back
        we = 1'b1; waddr = 4'h3; wdata = 4'h2;
        tick();
        chk("b2b_q3_first", 8'(q3), 8'h2);
        chk("b2b_ack_first", 8'(wr_ack), 8'h1);
        wdata = 4'h9;
        tick();
        chk("b2b_q3_second", 8'(q3), 8'h9);
        chk("b2b_ack_second", 8'(wr_ack), 8'h1);
        we = 1'b0;
        tick();
        chk("b2b_ack_off", 8'(wr_ack), 8'h0);

        // Full clear with writes attempted mid-clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        chk("clr_q0_first", 8'(q0), 8'h0);
        chk("clr_q1_first", 8'(q1), 8'hE);
        chk("clr_busy_first", 8'(clr_busy), 8'h1);
        chk("clr_done_first", 8'(clr_done), 8'h0);
        if (clr_busy) busy_cnt++;
        for (int k = 2; k <= 16; k++) begin
            we = (k == 5) || (k == 6);
            waddr = (k == 6) ? 4'h1 : 4'h7;
            wdata = 4'h6;
            tick();
            if (clr_busy) busy_cnt++;
            chk($sformatf("clr_ack_e%0d", k), 8'(wr_ack), 8'h0);
            chk($sformatf("clr_busy_e%0d", k), 8'(clr_busy), 8'(k < 16));
            chk($sformatf("clr_done_e%0d", k), 8'(clr_done), 8'(k == 16));
        end
        we = 1'b0;
        chk("clr_busy_cycles", 8'(busy_cnt), 8'd15);
        tick();
        chk("clr_done_single", 8'(clr_done), 8'h0);
        for (int i = 0; i < 16; i++) chk($sformatf("clr_q%0d", i), 8'(qv[i]), 8'h0);

        // Write/clear conflict in IDLE: clear wins
        we = 1'b1; waddr = 4'h2; wdata = 4'hC;
        tick();
        chk("pre_conf_q2", 8'(q2), 8'hC);
        wdata = 4'h5; clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0;
        chk("conf_ack", 8'(wr_ack), 8'h0);
        chk("conf_busy", 8'(clr_busy), 8'h1);
        chk("conf_q2_not_written", 8'(q2), 8'hC);
        for (int k = 2; k <= 16; k++) tick();
        chk("conf_done", 8'(clr_done), 8'h1);
        chk("conf_q2_cleared", 8'(q2), 8'h0);

        // Back-to-back clears with clr_req held
        clr_req = 1'b1;
        for (int k = 1; k <= 16; k++) tick();
        chk("btb_done", 8'(clr_done), 8'h1);
        chk("btb_busy_low", 8'(clr_busy), 8'h0);
        tick();
        chk("btb_restart_busy", 8'(clr_busy), 8'h1);
        chk("btb_restart_done", 8'(clr_done), 8'h0);
        clr_req = 1'b0;
        for (int k = 2; k <= 16; k++) tick();
        chk("btb_done2", 8'(clr_done), 8'h1);
        tick();

        // Abort a clear with reset after 8 edges
        for (int i = 10; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 4'h7;
            tick();
        end
        we = 1'b0;
        chk("abort_pre_qf", 8'(qf), 8'h7);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 2; k <= 8; k++) tick();
        chk("abort_busy_mid", 8'(clr_busy), 8'h1);
        chk("abort_qa_mid", 8'(qa), 8'h7);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 8'(clr_busy), 8'h0);
        chk("abort_done", 8'(clr_done), 8'h0);
        for (int i = 10; i < 16; i++) chk($sformatf("abort_q%0d", i), 8'(qv[i]), 8'h0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("abort_no_done%0d", k), 8'(clr_done), 8'h0);
        end
        chk("abort_idle_busy", 8'(clr_busy), 8'h0);

`ifdef REGBANK_WMASK_EN
        // Masked writes
        we = 1'b1; waddr = 4'h4; wdata = 4'hF; wmask = 4'hF;
        tick();
        chk("mask_q4_full", 8'(q4), 8'hF);
        wdata = 4'h0; wmask = 4'b0101;
        tick();
        chk("mask_q4_partial", 8'(q4), 8'hA);
        chk("mask_ack_partial", 8'(wr_ack), 8'h1);
        wdata = 4'h5; wmask = 4'b0000;
        tick();
        chk("mask_q4_zero", 8'(q4), 8'hA);
        chk("mask_ack_zero", 8'(wr_ack), 8'h1);
        we = 1'b0; wmask = 4'hF;
        tick();
        chk("mask_ack_off", 8'(wr_ack), 8'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
